// File: rtl/matrix_ser_tx.sv
// 2x2 matrix serializer: frames the four elements row-major on sdo
// inside an enc envelope, with a lead-in, inter-frame gap and one-deep queue.
module matrix_ser_tx #(
    parameter int DW   = 16,
    parameter int LEAD = 6,
    parameter int GAP  = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] m00,
    input  logic [DW-1:0] m01,
    input  logic [DW-1:0] m10,
    input  logic [DW-1:0] m11,
    output logic          enc,
    output logic [DW-1:0] sdo,
    output logic          sdo_valid,
    output logic [1:0]    sdo_idx,
    output logic          done,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SEND,
        ST_GAP
    } state_t;

    localparam logic [3:0] LEAD_LAST = 4'(LEAD - 1);
    localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

    state_t                state;
    state_t                state_n;
    logic [3:0]            cnt;
    logic [3:0]            cnt_n;
    logic [1:0]            idx;
    logic [1:0]            idx_n;
    logic [3:0][DW-1:0]    frame;
    logic [3:0][DW-1:0]    pending;
    logic [3:0][DW-1:0]    in_mat;
    logic                  pending_full;
    logic                  accept;
    logic                  start;
    logic                  load_in;
    logic                  load_pend;

    assign in_mat   = {m11, m10, m01, m00};
    assign in_ready = !pending_full;
    assign accept   = in_valid && in_ready && !rst;
    assign busy     = (state != ST_IDLE);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idx_n     = idx;
        start     = 1'b0;
        load_in   = 1'b0;
        load_pend = 1'b0;
        enc       = 1'b0;
        sdo_valid = 1'b0;
        sdo       = '0;
        sdo_idx   = '0;
        done      = 1'b0;

        unique case (state)
            ST_IDLE: begin
                // A matrix parked in pending while we dropped to idle wins
                if (pending_full) begin
                    start     = 1'b1;
                    load_pend = 1'b1;
                end else if (accept) begin
                    start   = 1'b1;
                    load_in = 1'b1;
                end
            end
            ST_LEAD: begin
                enc = 1'b1;
                if (cnt == 4'd0) begin
                    state_n = ST_SEND;
                    idx_n   = 2'd0;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            ST_SEND: begin
                enc       = 1'b1;
                sdo_valid = 1'b1;
                sdo       = frame[idx];
                sdo_idx   = idx;
                if (idx == 2'd3) begin
                    state_n = ST_GAP;
                    cnt_n   = GAP_LAST;
                end else begin
                    idx_n = idx + 2'd1;
                end
            end
            ST_GAP: begin
                done = (cnt == GAP_LAST);
                if (cnt == 4'd0) begin
                    if (pending_full) begin
                        start     = 1'b1;
                        load_pend = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // A zero-length lead-in goes straight to the first word
        if (start) begin
            if (LEAD == 0) begin
                state_n = ST_SEND;
                idx_n   = 2'd0;
            end else begin
                state_n = ST_LEAD;
                cnt_n   = LEAD_LAST;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            idx          <= 2'd0;
            frame        <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            if (load_in) begin
                frame <= in_mat;
            end else if (load_pend) begin
                frame <= pending;
            end
            if (load_pend) begin
                pending_full <= 1'b0;
            end else if (accept && !load_in) begin
                pending      <= in_mat;
                pending_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_matrix_ser_tx.sv
// Self-checking bench for matrix_ser_tx: directed frame timing, reset
// behaviour and a randomized stream against a frame-schedule model.
module tb_matrix_ser_tx;

    localparam int DW   = 16;
    localparam int LA   = 6;
    localparam int GA   = 2;
    localparam int NCYC = 1500;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] m00, m01, m10, m11;

    logic          a_ready, a_enc, a_sv, a_done, a_busy;
    logic [DW-1:0] a_sdo;
    logic [1:0]    a_idx;
    logic          b_ready, b_enc, b_sv, b_done, b_busy;
    logic [DW-1:0] b_sdo;
    logic [1:0]    b_idx;

    int checks = 0;
    int errors = 0;

    bit            e_enc  [2048];
    bit            e_sv   [2048];
    bit            e_done [2048];
    bit            e_busy [2048];
    logic [DW-1:0] e_sdo  [2048];
    logic [1:0]    e_idx  [2048];

    always #5 clk = ~clk;

    matrix_ser_tx #(.DW(DW), .LEAD(LA), .GAP(GA)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ready),
        .m00(m00), .m01(m01), .m10(m10), .m11(m11),
        .enc(a_enc), .sdo(a_sdo), .sdo_valid(a_sv), .sdo_idx(a_idx),
        .done(a_done), .busy(a_busy)
    );

    matrix_ser_tx #(.DW(DW), .LEAD(0), .GAP(1)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ready),
        .m00(m00), .m01(m01), .m10(m10), .m11(m11),
        .enc(b_enc), .sdo(b_sdo), .sdo_valid(b_sv), .sdo_idx(b_idx),
        .done(b_done), .busy(b_busy)
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_mat();
        m00 = DW'($urandom);
        m01 = DW'($urandom);
        m10 = DW'($urandom);
        m11 = DW'($urandom);
    endtask

    // in_valid is held high during reset; it must be ignored
    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        rand_mat();
        nxt();
        nxt();
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        rand_mat();
        nxt();
        checks++;
        if ({a_enc, a_sv, a_done, a_busy} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctl got %b exp 0000",
                     {a_enc, a_sv, a_done, a_busy});
        end
        checks++;
        if ({a_sdo, a_idx} !== '0) begin
            errors++;
            $display("FAIL reset_data got %h/%0d exp 0/0", a_sdo, a_idx);
        end
        nxt();
        rst      = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b%b exp 11", a_ready, b_ready);
        end
        nxt();
        checks++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ignore_valid busy got %b%b exp 00",
                     a_busy, b_busy);
        end
    endtask

    task automatic test_single();
        logic [DW-1:0] w[4];
        bit            x_enc, x_sv, x_done;
        logic [DW-1:0] x_sdo;
        logic [1:0]    x_idx;
        w = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        do_reset();
        m00 = w[0];
        m01 = w[1];
        m10 = w[2];
        m11 = w[3];
        in_valid = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            nxt();
            in_valid = 1'b0;
            x_enc  = (k >= 1 && k <= 10);
            x_sv   = (k >= 7 && k <= 10);
            x_done = (k == 11);
            x_sdo  = '0;
            x_idx  = '0;
            if (x_sv) begin
                x_sdo = w[k-7];
                x_idx = 2'(k - 7);
            end
            checks++;
            if (a_enc !== x_enc) begin
                errors++;
                $display("FAIL single_enc T+%0d got %b exp %b", k, a_enc, x_enc);
            end
            checks++;
            if (a_sv !== x_sv) begin
                errors++;
                $display("FAIL single_sv T+%0d got %b exp %b", k, a_sv, x_sv);
            end
            checks++;
            if (a_sdo !== x_sdo || a_idx !== x_idx) begin
                errors++;
                $display("FAIL single_sdo T+%0d got %h/%0d exp %h/%0d",
                         k, a_sdo, a_idx, x_sdo, x_idx);
            end
            checks++;
            if (a_done !== x_done) begin
                errors++;
                $display("FAIL single_done T+%0d got %b exp %b", k, a_done, x_done);
            end
        end
    endtask

    task automatic test_lead0();
        logic [DW-1:0] w[4];
        do_reset();
        rand_mat();
        m00 = 16'hFFFF;
        w = '{m00, m01, m10, m11};
        in_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            nxt();
            in_valid = 1'b0;
            if (k <= 4) begin
                checks++;
                if (b_enc !== 1'b1 || b_sv !== 1'b1 || b_sdo !== w[k-1]
                    || b_idx !== 2'(k - 1)) begin
                    errors++;
                    $display("FAIL lead0_word T+%0d got %b%b %h/%0d exp 11 %h/%0d",
                             k, b_enc, b_sv, b_sdo, b_idx, w[k-1], k - 1);
                end
            end
            checks++;
            if (b_done !== (k == 5)) begin
                errors++;
                $display("FAIL lead0_done T+%0d got %b exp %b", k, b_done, k == 5);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] ma[4], mb[4], mc[4], ex[$], got[$];
        int  kc, cst, low_run;
        bit  seen;
        do_reset();
        rand_mat(); ma = '{m00, m01, m10, m11};
        rand_mat(); mb = '{m00, m01, m10, m11};
        rand_mat(); mc = '{m00, m01, m10, m11};
        ex = {ma[0], ma[1], ma[2], ma[3], mb[0], mb[1], mb[2], mb[3],
              mc[0], mc[1], mc[2], mc[3]};
        {m00, m01, m10, m11} = {ma[0], ma[1], ma[2], ma[3]};
        in_valid = 1'b1;
        kc = -1; cst = 0; low_run = 0; seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            nxt();
            if (cst == 2 && kc == k - 1) in_valid = 1'b0;
            if (a_sv) begin
                checks++;
                if (a_idx !== 2'(got.size() % 4)) begin
                    errors++;
                    $display("FAIL b2b_idx T+%0d got %0d exp %0d",
                             k, a_idx, got.size() % 4);
                end
                got.push_back(a_sdo);
            end
            if (!a_enc) begin
                low_run++;
            end else begin
                if (seen && low_run > 0) begin
                    checks++;
                    if (low_run < GA) begin
                        errors++;
                        $display("FAIL b2b_gap T+%0d got %0d exp >=%0d",
                                 k, low_run, GA);
                    end
                end
                low_run = 0;
                seen = 1'b1;
            end
            if (k == 4) begin
                checks++;
                if (a_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_ready_drop got %b exp 0", a_ready);
                end
            end
            if (k == 12 || k == 13) begin
                checks++;
                if (a_enc !== (k == 13) || a_ready !== (k == 13)) begin
                    errors++;
                    $display("FAIL b2b_drain T+%0d got enc %b rdy %b exp %b",
                             k, a_enc, a_ready, k == 13);
                end
            end
            if (k == 1) in_valid = 1'b0;
            if (k == 3) begin
                {m00, m01, m10, m11} = {mb[0], mb[1], mb[2], mb[3]};
                in_valid = 1'b1;
            end
            if (k == 4) begin
                {m00, m01, m10, m11} = {mc[0], mc[1], mc[2], mc[3]};
                in_valid = 1'b1;
                cst = 1;
            end
            if (cst == 1 && a_ready) begin
                kc = k;
                cst = 2;
            end
        end
        checks++;
        if (kc != 13) begin
            errors++;
            $display("FAIL b2b_third_accept got T+%0d exp T+13", kc);
        end
        checks++;
        if (got.size() != 12) begin
            errors++;
            $display("FAIL b2b_count got %0d exp 12", got.size());
        end
        for (int i = 0; i < 12 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== ex[i]) begin
                errors++;
                $display("FAIL b2b_word %0d got %h exp %h", i, got[i], ex[i]);
            end
        end
    endtask

    task automatic test_rst_mid();
        logic [DW-1:0] ma[4], md[4];
        do_reset();
        rand_mat();
        ma = '{m00, m01, m10, m11};
        in_valid = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            nxt();
            if (k == 1) in_valid = 1'b0;
            if (k == 3) begin
                rand_mat();
                in_valid = 1'b1;
            end
            if (k == 4) in_valid = 1'b0;
        end
        checks++;
        if (a_sv !== 1'b1 || a_idx !== 2'd2 || a_sdo !== ma[2]) begin
            errors++;
            $display("FAIL rstmid_pre got %b %0d %h exp 1 2 %h",
                     a_sv, a_idx, a_sdo, ma[2]);
        end
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        checks++;
        if ({a_enc, a_sv, a_done, a_busy, a_ready} !== 5'b00001
            || a_sdo !== '0) begin
            errors++;
            $display("FAIL rstmid_abort got %b sdo %h exp 00001 sdo 0",
                     {a_enc, a_sv, a_done, a_busy, a_ready}, a_sdo);
        end
        for (int k = 0; k < 15; k++) begin
            nxt();
            checks++;
            if (a_done !== 1'b0 || a_busy !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_quiet +%0d got done %b busy %b exp 0 0",
                         k, a_done, a_busy);
            end
        end
        rand_mat();
        md = '{m00, m01, m10, m11};
        in_valid = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            nxt();
            in_valid = 1'b0;
            if (k >= 7 && k <= 10) begin
                checks++;
                if (a_sv !== 1'b1 || a_sdo !== md[k-7]) begin
                    errors++;
                    $display("FAIL rstmid_refr T+%0d got %b %h exp 1 %h",
                             k, a_sv, a_sdo, md[k-7]);
                end
            end
            if (k == 11) begin
                checks++;
                if (a_done !== 1'b1) begin
                    errors++;
                    $display("FAIL rstmid_done got %b exp 1", a_done);
                end
            end
        end
    endtask

    // Model: frame k starts enc at s_k; it occupies enc for LA+4 cycles and
    // busy through its gap. A matrix accepted while a frame is active starts
    // right after that gap, or one cycle later if offered in its last cycle.
    task automatic test_random();
        int last_a, last_s, last_l, s, rate;
        bit ex_rdy;
        logic [DW-1:0] mat[4];
        for (int i = 0; i < 2048; i++) begin
            e_enc[i] = 0; e_sv[i] = 0; e_done[i] = 0; e_busy[i] = 0;
            e_sdo[i] = '0; e_idx[i] = '0;
        end
        do_reset();
        last_a = -100; last_s = -100; last_l = -100;
        for (int c = 0; c < NCYC; c++) begin
            ex_rdy = !(last_a < c && c < last_s);
            checks++;
            if (a_ready !== ex_rdy) begin
                errors++;
                $display("FAIL rnd_ready c%0d got %b exp %b", c, a_ready, ex_rdy);
            end
            checks++;
            if ({a_enc, a_sv, a_done, a_busy} !==
                {e_enc[c], e_sv[c], e_done[c], e_busy[c]}) begin
                errors++;
                $display("FAIL rnd_ctl c%0d got %b exp %b", c,
                         {a_enc, a_sv, a_done, a_busy},
                         {e_enc[c], e_sv[c], e_done[c], e_busy[c]});
            end
            checks++;
            if (a_sdo !== e_sdo[c] || a_idx !== e_idx[c]) begin
                errors++;
                $display("FAIL rnd_data c%0d got %h/%0d exp %h/%0d",
                         c, a_sdo, a_idx, e_sdo[c], e_idx[c]);
            end
            if (!(in_valid && !ex_rdy)) begin
                rate = (c / 250) % 3;
                in_valid = ($urandom_range(0, rate * 3) == 0);
                rand_mat();
            end
            if (in_valid && ex_rdy) begin
                mat = '{m00, m01, m10, m11};
                if (c > last_l) s = c + 1;
                else if (c == last_l) s = c + 2;
                else s = last_l + 1;
                for (int j = 0; j <= LA + 3; j++) e_enc[s+j] = 1;
                for (int j = 0; j <= LA + 3 + GA; j++) e_busy[s+j] = 1;
                for (int j = 0; j < 4; j++) begin
                    e_sv[s+LA+j]  = 1;
                    e_sdo[s+LA+j] = mat[j];
                    e_idx[s+LA+j] = 2'(j);
                end
                e_done[s+LA+4] = 1;
                last_a = c;
                last_s = s;
                last_l = s + LA + 3 + GA;
            end
            nxt();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        {m00, m01, m10, m11} = '0;
        test_reset();
        test_single();
        test_lead0();
        test_back_to_back();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_ser_tx.md
MATRIX_SER_TX -- requirements
Module: matrix_ser_tx

Interface
REQ-001 SHALL have parameter DW, default 16, meaning the width of each matrix element and of sdo.
REQ-002 SHALL have parameter LEAD, default 6, range 0..15, meaning the number of cycles enc is high before the first word is sent.
REQ-003 SHALL have parameter GAP, default 2, range 1..15, meaning the minimum number of cycles enc is low between frames.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  a 2x2 matrix is offered on m00..m11.
REQ-007 in_ready  output  1  the block can accept a matrix this cycle.
REQ-008 m00, m01, m10, m11  input  DW each  matrix elements; sampled only on accept.
REQ-009 enc  output  1  frame envelope; high from frame start through the last word.
REQ-010 sdo  output  DW  serial data word.
REQ-011 sdo_valid  output  1  sdo carries a frame word this cycle.
REQ-012 sdo_idx  output  2  index of the current word: 0=m00, 1=m01, 2=m10, 3=m11.
REQ-013 done  output  1  one-cycle pulse after a frame completes.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 Accept SHALL occur on any rising edge where in_valid and in_ready are both high; all four elements are captured together.
REQ-016 Storage SHALL be one active frame register plus one pending register; in_ready = !pending_full.
REQ-017 The FSM SHALL have exactly these states: IDLE, LEAD, SEND, GAP.
REQ-018 IDLE: on accept (or pending_full), the frame register loads and the FSM enters LEAD; enc = 1 from the next cycle.
REQ-019 LEAD: enc high, sdo_valid low, for LEAD cycles, then SEND; if LEAD = 0, the FSM goes directly from IDLE to SEND.
REQ-020 SEND: 4 consecutive cycles with sdo_valid = 1, enc = 1, sdo_idx 0,1,2,3, and sdo = m00, m01, m10, m11 in row-major order.
REQ-021 Timing: if accept happens at edge T, the word at idx 0 SHALL appear in cycle T+1+LEAD and the word at idx 3 in cycle T+4+LEAD.
REQ-022 The cycle after idx 3: enc = 0, sdo_valid = 0, done = 1 for one cycle, and the FSM enters GAP.
REQ-023 GAP: enc stays low for GAP cycles; then, if pending_full, pending moves to the frame register, pending clears and the FSM enters LEAD (or SEND if LEAD = 0); otherwise it enters IDLE.
REQ-024 An accept during LEAD, SEND or GAP SHALL fill the pending register and SHALL NOT disturb the active frame.
REQ-025 Accept and pending-drain in the same cycle: this cannot occur, because in_ready is low while pending_full.
REQ-026 When sdo_valid = 0, sdo and sdo_idx SHALL be driven to 0.
REQ-027 Counters SHALL use 4 bits for LEAD/GAP and 2 bits for the word index; there is no wrap beyond idx 3.
REQ-028 Frames SHALL be sent in accept order; no matrix is dropped or duplicated.

Reset
REQ-029 While rst is high at a clock edge: FSM = IDLE; enc, sdo_valid, done, busy = 0; sdo, sdo_idx = 0; pending cleared; in_ready = 1 from the first cycle after rst.
REQ-030 rst mid-frame (LEAD, SEND or GAP) SHALL abort the frame: no done pulse, and the pending matrix is discarded.
REQ-031 in_valid SHALL be ignored during any cycle in which rst is high.

Verification
REQ-032 Single frame, LEAD=6, accept at T with m00=0x0010, m01=0x0020, m10=0x0030, m11=0x0040 -> enc rises at T+1; sdo = 0x0010..0x0040 at T+7..T+10; done at T+11.
REQ-033 Back-to-back: second matrix offered at T+3 -> in_ready drops at T+4; second frame enc rises at T+11+GAP; words are in order; in_ready returns high one cycle after the pending drain.
REQ-034 Third offer while pending_full -> in_ready = 0 and in_valid held; accepted only after the drain; all three frames emitted in order.
REQ-035 LEAD=0, accept at T with m00=0xFFFF -> enc and sdo_valid both rise at T+1 with sdo = 0xFFFF and sdo_idx = 0.
REQ-036 rst asserted in SEND at idx 2 -> next cycle: enc = 0, sdo = 0, no done pulse; a new accept afterwards produces a full normal frame.
REQ-037 Loopback into the team's trace unit with m00=0x0005, m11=0x0007 -> trace result 0x000C; enc low for at least GAP cycles between frames.
